// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo responder.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_echo_fifo.sv
// Echo buffer: DEPTH-entry FIFO with a combinational head on dout.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Far-end UART responder: receives 8N1 frames, buffers them and echoes them back.
// Optional macro UART_ECHO_FRAME_CHECK_EN: reject frames with a low stop bit and
// report them on frame_err.
//
// RX state    | meaning
// R_IDLE      | waiting for a falling edge on the synced line
// R_START     | timing to mid start bit, rejecting glitches
// R_DATA      | sampling 8 data bits, LSB first
// R_STOP      | sampling stop bit, committing the byte
// R_WAIT_IDLE | after a framing error, waiting for one full high bit
//
// TX state    | meaning
// T_IDLE      | line high, pops the FIFO head when available
// T_START     | driving start bit (0)
// T_DATA      | driving 8 data bits, LSB first
// T_STOP      | driving stop bit (1)
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2500,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_rx,
  output logic                          serial_tx,
  output logic [7:0]                    incoming,
  output logic                          rx_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef UART_ECHO_FRAME_CHECK_EN
  output logic                          frame_err,
`endif
  output logic                          overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta, rx_sync, rx_prev;

  rx_state_t   rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        rx_commit;
`ifdef UART_ECHO_FRAME_CHECK_EN
  logic        rx_ferr;
`endif

  tx_state_t   tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick;
  logic        tx_pop;

  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  assign rx_tick = (rx_cnt == '0);
  assign tx_tick = (tx_cnt == '0);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= serial_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  // RX next-state logic.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_prev && !rx_sync) rx_next = R_START;
      R_START: if (rx_tick) rx_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = R_STOP;
`ifdef UART_ECHO_FRAME_CHECK_EN
      R_STOP:      if (rx_tick) rx_next = rx_sync ? R_IDLE : R_WAIT_IDLE;
      R_WAIT_IDLE: if (rx_tick && rx_sync) rx_next = R_IDLE;
`else
      R_STOP:      if (rx_tick) rx_next = R_IDLE;
`endif
      default: rx_next = R_IDLE;
    endcase
  end

  // RX output decode: commit (and framing error) on the stop sample.
  always_comb begin
    rx_commit = 1'b0;
`ifdef UART_ECHO_FRAME_CHECK_EN
    rx_ferr   = 1'b0;
    if (rx_state == R_STOP && rx_tick) begin
      rx_commit = rx_sync;
      rx_ferr   = !rx_sync;
    end
`else
    if (rx_state == R_STOP && rx_tick) rx_commit = 1'b1;
`endif
  end

  // RX bit timer (down-counter), shift register and committed-byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      incoming  <= '0;
      rx_ready  <= 1'b0;
`ifdef UART_ECHO_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_ready  <= rx_commit;
      if (rx_commit) incoming <= rx_shift;
`ifdef UART_ECHO_FRAME_CHECK_EN
      frame_err <= rx_ferr;
`endif
      case (rx_state)
        R_IDLE: begin
          rx_cnt <= CNT_HALF;
          rx_bit <= '0;
        end
        R_WAIT_IDLE: begin
          // Any low sample restarts the full-bit high window.
          if (!rx_sync || rx_tick) rx_cnt <= CNT_BIT;
          else                     rx_cnt <= rx_cnt - 1'b1;
        end
        default: begin
          if (rx_tick) rx_cnt <= CNT_BIT;
          else         rx_cnt <= rx_cnt - 1'b1;
          if (rx_state == R_DATA && rx_tick) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
          end
        end
      endcase
    end
  end

  uart_echo_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rx_ready),
    .pop  (tx_pop),
    .din  (incoming),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Sticky drop flag: a push at full only loses data when no pop coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               overflow <= 1'b0;
    else if (rx_ready && fifo_full && !tx_pop) overflow <= 1'b1;
  end

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= T_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next-state logic.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (!fifo_empty) tx_next = T_START;
      T_START: if (tx_tick) tx_next = T_DATA;
      T_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = T_STOP;
      T_STOP:  if (tx_tick) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  // TX outputs: line level is decoded straight from state so reset idles it at once.
  always_comb begin
    serial_tx = 1'b1;
    case (tx_state)
      T_START: serial_tx = 1'b0;
      T_DATA:  serial_tx = tx_shift[0];
      default: serial_tx = 1'b1;
    endcase
    busy   = (tx_state != T_IDLE);
    tx_pop = (tx_state == T_IDLE) && !fifo_empty;
  end

  // TX bit timer (down-counter) and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state == T_IDLE) begin
        tx_cnt <= CNT_BIT;
        tx_bit <= '0;
        if (tx_pop) tx_shift <= fifo_dout;
      end else begin
        if (tx_tick) tx_cnt <= CNT_BIT;
        else         tx_cnt <= tx_cnt - 1'b1;
        if (tx_state == T_DATA && tx_tick) begin
          tx_shift <= {1'b1, tx_shift[7:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end
    end
  end

endmodule
